// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with an integrated transmit FIFO, paced by an external baud pulse.
// The frame format is captured when a character is loaded, so software may reprogram it mid-frame.
module uart_tx_fifo_param #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_pulse,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        num_bits,
  input  logic [2:0]        parity_mode,
  input  logic              stop2,
  input  logic              send_break,
  output logic              tx,
  output logic              txrdy,
  output logic              fifo_empty,
  output logic [AW:0]       fifo_count,
  output logic              tx_busy,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;

  localparam logic [3:0]  MAX_BITS = 4'(DATA_W);
  localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop, loaded;

  state_t            state, state_next;
  logic              tx_next;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        bit_cnt, bit_cnt_next, eff_bits, sh_bits;
  logic              sh_par_en, sh_stop2, par_bit, load_par;

  // The FIFO is popped exactly once, on the first cycle spent in LOAD.
  assign pop  = (state == LOAD) && !loaded;
  assign push = wr_en && ((count != DEPTH) || pop);

  assign txrdy      = (count != DEPTH);
  assign fifo_empty = (count == '0);
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      overflow <= wr_en && !push;
    end
  end

  // Clamped length and parity of the head-of-FIFO word, captured into the shadows on pop.
  always_comb begin
    eff_bits = num_bits;
    if (num_bits < 4'd5)          eff_bits = 4'd5;
    else if (num_bits > MAX_BITS) eff_bits = MAX_BITS;
    load_par = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < eff_bits) load_par = load_par ^ mem[rd_ptr][i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      loaded  <= 1'b0;
    end else begin
      state   <= state_next;
      tx      <= tx_next;
      bit_cnt <= bit_cnt_next;
      loaded  <= (state == LOAD) && (state_next == LOAD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      sh_bits   <= 4'd5;
      sh_par_en <= 1'b0;
      par_bit   <= 1'b0;
      sh_stop2  <= 1'b0;
    end else begin
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        sh_bits   <= eff_bits;
        sh_par_en <= (parity_mode >= 3'd1) && (parity_mode <= 3'd4);
        sh_stop2  <= stop2;
        case (parity_mode)
          3'd1:    par_bit <= load_par;
          3'd2:    par_bit <= ~load_par;
          3'd3:    par_bit <= 1'b1;
          default: par_bit <= 1'b0;
        endcase
      end else if (state == DATA && baud_pulse) begin
        shift_reg <= shift_reg >> 1;
      end
      if (state == IDLE && state_next == BREAK) sh_stop2 <= stop2;
    end
  end

  always_comb begin
    state_next   = state;
    tx_next      = tx;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (send_break) begin
          if (baud_pulse) begin
            state_next = BREAK;
            tx_next    = 1'b0;
          end
        end else if (count != '0) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (baud_pulse) begin
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_pulse) begin
          state_next   = DATA;
          tx_next      = shift_reg[0];
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (baud_pulse) begin
          if (bit_cnt == sh_bits - 4'd1) begin
            state_next = sh_par_en ? PARITY : STOP1;
            tx_next    = sh_par_en ? par_bit : 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
            tx_next      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (baud_pulse) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end
      end
      STOP1: begin
        if (baud_pulse) begin
          state_next = sh_stop2 ? STOP2 : IDLE;
          tx_next    = 1'b1;
        end
      end
      STOP2: begin
        if (baud_pulse) begin
          state_next = IDLE;
          tx_next    = 1'b1;
        end
      end
      BREAK: begin
        tx_next = 1'b0;
        if (!send_break && baud_pulse) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
